// File: rtl/acc_pkg.sv
// Shared definitions for the accumulation-chain send/receive controllers.
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } acc_state_e;

  localparam int ACC_DATA_W = 32;

  // Index width with a floor of 1 so DEPTH=1 still has a usable address bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/acc_skid_buf.sv
// Output register plus one skid entry; occ counts both entries and reads still in flight.
module acc_skid_buf import acc_pkg::*; #(
  parameter int DATA_W = ACC_DATA_W,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              in_vld,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ready,
  output logic              out_vld,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              fire,
  output logic [1:0]        occ
);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t out_q, skid_q, in_e;
  logic skid_vld;

  assign in_e     = '{idx: in_idx, data: in_data};
  assign fire     = out_vld & ready;
  assign out_idx  = out_q.idx;
  assign out_data = out_q.data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld  <= 1'b0;
      out_q    <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
      occ      <= '0;
    end else begin
      occ <= occ + 2'(issue) - 2'(fire);
      if (fire || !out_vld) begin
        // Skid is older than anything arriving, so it always wins the output slot.
        if (skid_vld) begin
          out_q    <= skid_q;
          skid_q   <= in_e;
          skid_vld <= in_vld;
        end else begin
          out_vld <= in_vld;
          if (in_vld) out_q <= in_e;
        end
      end else if (in_vld) begin
        skid_q   <= in_e;
        skid_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_send_ctrl.sv
// Transmit controller: streams DEPTH accumulator words to the next PE over valid/ready.
module acc_send_ctrl import acc_pkg::*; #(
  parameter int DATA_W = ACC_DATA_W,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              acc_done_in,
  output logic              buf_rd_en,
  output logic [IDX_W-1:0]  buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              acc_valid_out,
  output logic [IDX_W-1:0]  acc_idx_out,
  output logic [DATA_W-1:0] acc_data_out,
  output logic              busy,
  output logic              send_done
);

  localparam int               STAGES   = 1;
  localparam logic [IDX_W:0]   LAST_PTR = (IDX_W+1)'(DEPTH-1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH-1);

  acc_state_e       state, state_nxt;
  logic [IDX_W:0]   rd_ptr;
  logic [STAGES:0]  vld_pipe;
  logic [STAGES:1]  vld_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic             fire, last_rd, last_fire;
  logic [1:0]       occ;

  assign buf_rd_addr = rd_ptr[IDX_W-1:0];
  assign last_rd     = buf_rd_en && (rd_ptr == LAST_PTR);
  assign last_fire   = fire && (acc_idx_out == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = ISSUE;
      ISSUE:   if (last_rd)   state_nxt = DRAIN;
      DRAIN:   if (last_fire) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // A slot freed by this cycle's fire can be refilled by a read issued the same cycle.
  always_comb begin
    busy      = (state != IDLE);
    buf_rd_en = (state == ISSUE) && ((occ - 2'(fire)) < 2'd2);
  end

  // Read-data valid tracks the one-cycle buffer latency.
  assign vld_pipe = {vld_q, buf_rd_en};

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr    <= '0;
      vld_q     <= '0;
      rd_idx_q  <= '0;
      send_done <= 1'b0;
    end else begin
      if (state == IDLE && start) rd_ptr <= '0;
      else if (buf_rd_en)         rd_ptr <= rd_ptr + 1'b1;
      vld_q     <= vld_pipe[STAGES-1:0];
      rd_idx_q  <= buf_rd_addr;
      send_done <= (state == DRAIN) && last_fire;
    end
  end

  acc_skid_buf #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .issue    (buf_rd_en),
    .in_vld   (vld_pipe[STAGES]),
    .in_idx   (rd_idx_q),
    .in_data  (buf_rd_data),
    .ready    (acc_done_in),
    .out_vld  (acc_valid_out),
    .out_idx  (acc_idx_out),
    .out_data (acc_data_out),
    .fire     (fire),
    .occ      (occ)
  );

endmodule

// File: tb/tb_acc_send_ctrl.sv
// Bench for acc_send_ctrl: transfer-level reference model with directed and random ready patterns.
module tb_acc_send_ctrl;

  localparam int DEPTH = 16;

  logic        clk, rst;
  logic        start, acc_done_in, buf_rd_en, acc_valid_out, busy, send_done;
  logic [3:0]  buf_rd_addr, acc_idx_out;
  logic [31:0] buf_rd_data, acc_data_out;

  logic        start1, acc_done_in1, buf_rd_en1, acc_valid_out1, busy1, send_done1;
  logic [0:0]  buf_rd_addr1, acc_idx_out1;
  logic [31:0] buf_rd_data1, acc_data_out1;

  logic [31:0] mem [DEPTH];
  logic [31:0] w1;
  int checks = 0;
  int errors = 0;
  int done_c, done_c2;

  acc_send_ctrl #(.DATA_W(32), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .start(start), .acc_done_in(acc_done_in),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .acc_valid_out(acc_valid_out), .acc_idx_out(acc_idx_out), .acc_data_out(acc_data_out),
    .busy(busy), .send_done(send_done)
  );

  acc_send_ctrl #(.DATA_W(32), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .acc_done_in(acc_done_in1),
    .buf_rd_en(buf_rd_en1), .buf_rd_addr(buf_rd_addr1), .buf_rd_data(buf_rd_data1),
    .acc_valid_out(acc_valid_out1), .acc_idx_out(acc_idx_out1), .acc_data_out(acc_data_out1),
    .busy(busy1), .send_done(send_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator buffers: one-cycle read latency.
  always @(posedge clk) begin
    if (buf_rd_en)  buf_rd_data  <= mem[buf_rd_addr];
    if (buf_rd_en1) buf_rd_data1 <= w1 ^ {31'b0, buf_rd_addr1};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input bit seq);
    for (int i = 0; i < DEPTH; i++) mem[i] = seq ? 32'(i + 100) : $urandom;
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return !(c >= 3 && c <= 7);
      2:       return (c % 2) == 1;
      3:       return $urandom_range(0, 3) != 0;
      default: return 1'(($urandom_range(0, 1)));
    endcase
  endfunction

  // Called inside cycle 0. Reference: valid from cycle 3 until DEPTH words have left;
  // the k-th ready-high cycle from cycle 3 carries index k. Returns the send_done cycle.
  task automatic run_xfer(input int mode, input bit inject, input bit chain, output int done_c_o);
    int c, k, reads, last;
    bit exp_v, r;
    c = 0; k = 0; reads = 0; last = -10; done_c_o = -1;
    start = 1'b1;
    acc_done_in = rdy(mode, 0);
    while (1) begin
      @(posedge clk); #1;
      c++;
      start = inject && (c == 5 || c == 10);
      r = rdy(mode, c);
      acc_done_in = r;
      @(negedge clk);
      exp_v = (c >= 3) && (k < DEPTH);
      chk("valid", acc_valid_out, exp_v);
      if (exp_v) begin
        chk("idx", acc_idx_out, k);
        chk("data", acc_data_out, mem[k]);
      end
      chk("busy", busy, k < DEPTH);
      chk("send_done", send_done, k == DEPTH);
      if (c == 1) chk("first_rd", buf_rd_en, 1);
      if (buf_rd_en) begin
        chk("rd_addr", buf_rd_addr, reads);
        reads++;
      end
      if (k == DEPTH && c == last + 1) begin
        chk("rd_count", reads, DEPTH);
        done_c_o = c;
        start = chain;
        break;
      end
      if (exp_v && r) begin
        k++;
        if (k == DEPTH) last = c;
      end
      chk("buffered_le_2", (reads - k) <= 2, 1);
      if (c >= 300) begin
        chk("timeout_words", k, DEPTH);
        start = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_valid", acc_valid_out, 0);
    chk("idle_rd_en", buf_rd_en, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; acc_done_in = 1'b0;
    start1 = 1'b0; acc_done_in1 = 1'b0; w1 = $urandom;
    fill(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", acc_valid_out, 0);
    chk("rst_idx", acc_idx_out, 0);
    chk("rst_data", acc_data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", send_done, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_addr", buf_rd_addr, 0);
    chk("rst1_valid", acc_valid_out1, 0);
    chk("rst1_busy", busy1, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Full-rate transfer with sequential data
    @(posedge clk); #1;
    run_xfer(0, 0, 0, done_c);
    chk("full_done_cycle", done_c, 19);
    idle_cycle();

    // Ready low in cycles 3..7
    run_xfer(1, 0, 0, done_c);
    chk("stall_done_cycle", done_c, 24);
    idle_cycle();

    // Ready toggling every cycle, random data
    fill(0);
    run_xfer(2, 0, 0, done_c);
    idle_cycle();

    // Starts mid-transfer are ignored; start in the send_done cycle chains
    fill(0);
    run_xfer(0, 1, 1, done_c);
    chk("inject_done_cycle", done_c, 19);
    run_xfer(0, 0, 0, done_c2);
    chk("chain_done_cycle", done_c2, 19);
    idle_cycle();

    // Reset asserted in cycle 6 of a transfer
    start = 1'b1; acc_done_in = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", acc_valid_out, 0);
    chk("mid_rst_idx", acc_idx_out, 0);
    chk("mid_rst_data", acc_data_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", send_done, 0);
    chk("mid_rst_rd_en", buf_rd_en, 0);
    chk("mid_rst_addr", buf_rd_addr, 0);
    idle_cycle();
    fill(0);
    run_xfer(0, 0, 0, done_c);
    chk("restart_done_cycle", done_c, 19);

    // Random ready patterns
    for (int t = 0; t < 4; t++) begin
      idle_cycle();
      fill(0);
      run_xfer(3 + (t % 2), 0, 0, done_c);
    end

    // DEPTH=1 instance
    @(posedge clk); #1;
    start1 = 1'b1; acc_done_in1 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      @(negedge clk);
      chk("d1_busy", busy1, c <= 3);
      chk("d1_rd_en", buf_rd_en1, c == 1);
      if (c == 1) chk("d1_rd_addr", buf_rd_addr1, 0);
      chk("d1_valid", acc_valid_out1, c == 3);
      if (c == 3) begin
        chk("d1_idx", acc_idx_out1, 0);
        chk("d1_data", acc_data_out1, w1);
      end
      chk("d1_send_done", send_done1, c == 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_send_ctrl.md
# acc_send_ctrl

Transmit-side controller for the PE-to-PE accumulation chain. On `start`, it reads `DEPTH` partial sums from the local accumulator buffer (index 0 upward) and presents them to the next PE as index/data pairs under a valid/ready handshake. The downstream receive controller's ready output (`acc_done_out` on its side) drives this block's `acc_done_in`. The block sits in each PE beside the receive controller, on the opposite end of the same link.

## Interface
- `DATA_W`, 32: width of one accumulator word.
- `DEPTH`, 16: words per transfer; must be ≥1.
- `IDX_W`, `$clog2(DEPTH)` (minimum 1): width of the index/address.

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `acc_done_in`  in  1  downstream ready; a word transfers in a cycle with `acc_valid_out & acc_done_in`.
- `buf_rd_en`  out  1  buffer read strobe.
- `buf_rd_addr`  out  IDX_W  buffer read index.
- `buf_rd_data`  in  DATA_W  read data, valid exactly one cycle after `buf_rd_en`.
- `acc_valid_out`  out  1  index/data valid to next PE.
- `acc_idx_out`  out  IDX_W  index of the presented word.
- `acc_data_out`  out  DATA_W  presented word.
- `busy`  out  1  high outside IDLE.
- `send_done`  out  1  one-cycle pulse after the last word transfers.

## Operation
- States:
  - IDLE: no reads; waits for `start`.
  - ISSUE: reads still to issue.
  - DRAIN: all `DEPTH` reads issued; waits for the last transfer.
- Transitions:
  - IDLE→ISSUE on `start`.
  - ISSUE→DRAIN in the cycle the read of index `DEPTH-1` issues.
  - DRAIN→IDLE on the fire of index `DEPTH-1`; `send_done` pulses the next cycle.
- Read pointer `rd_ptr` (IDX_W+1 bits) is cleared on IDLE→ISSUE and increments on each `buf_rd_en`. `buf_rd_addr = rd_ptr[IDX_W-1:0]`. It never wraps; reads stop after `DEPTH`.
- Occupancy counts words held in the output register, the skid register, and in-flight reads (0..2).
- Read issue rule: `buf_rd_en = (state==ISSUE) && (occupancy - fire) < 2`. No buffered word is ever overwritten or dropped.
- Returned data loads the output register if it is empty or firing this cycle; otherwise it loads the skid register. On fire, skid moves to the output register.
- Words leave strictly in index order 0..DEPTH-1, each exactly once.
- `acc_idx_out` and `acc_data_out` hold stable while `acc_valid_out & ~acc_done_in`.
- `start` outside IDLE is ignored. `start` in the `send_done` cycle is accepted (state is IDLE).
- Reset values: all outputs 0, state IDLE, pointers and occupancy 0, skid empty. A reset mid-transfer discards in-flight read data.

## Timing
- `start` high in cycle 0:
  - `busy` and `buf_rd_en` (addr 0) high in cycle 1.
  - Data returns in cycle 2.
  - `acc_valid_out` with index 0 in cycle 3.
- With `acc_done_in` held high: one word per cycle, indices 0..DEPTH-1 in cycles 3..DEPTH+2, `send_done` in cycle DEPTH+3, `busy` low from DEPTH+3.
- Ready drop: valid stays high, at most 2 words are buffered, and reads pause. When ready returns, transfer resumes at full rate the same cycle with no bubble.
- DEPTH=1: ISSUE lasts one cycle, then DRAIN. Index 0 is presented in cycle 3.

## Structure
- Shared package `acc_pkg`: state enum (IDLE/ISSUE/DRAIN) and default `DATA_W`; the same package is used by the receive controller.
- One sub-module, `acc_skid_buf`: a 2-entry (output plus skid) register pair with occupancy tracking. The top level holds the FSM, pointer and issue logic.

## Test plan
- Reset, then `start` with `acc_done_in`=1 and DEPTH=16, buffer[i]=i+100: idx 0..15 / data 100..115 in cycles 3..18, `send_done` in cycle 19, no extra `buf_rd_en`.
- `acc_done_in` low in cycles 3..7, then high: idx 0 held stable with data 100; at most 2 reads issued before cycle 8; idx 0..15 complete gap-free from cycle 8; `send_done` in cycle 24.
- `acc_done_in` toggling each cycle: 16 transfers in order, no duplicate or missing index, data never changes while stalled.
- `start` pulsed in cycles 5 and 10 mid-transfer: ignored, single `send_done`. Back-to-back `start` in the `send_done` cycle: second transfer begins one cycle later.
- `rst` low in cycle 6 mid-transfer: all outputs 0 next cycle, state IDLE. A fresh `start` restarts at idx 0.
- DEPTH=1 build: one transfer, idx 0, in cycle 3, `send_done` in cycle 4.
